buffer_reader: RTL and testbench

- Consumer side of the feature buffer_unit register chain. Samples each stored feature word and drives the unit's hold control (1 = hold, 0 = load) for back-pressure.
- Re-times words through a small first-word-fall-through FIFO onto a valid/ready stream with a frame-end marker.
- Sits between the feature buffer stage and the next layer's input port.

---
 rtl/buffer_reader.sv | 77 +++++++
 tb/tb_buffer_reader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/buffer_reader.sv
// buffer_reader: first-word-fall-through FIFO that re-times buffer_unit words onto a valid/ready stream with out_last.
// Optional BUFFER_READER_STALL_CNT_EN adds stall_cnt, a saturating count of refused-word cycles.
`ifndef FEATURE_IN_WIDTH
`define FEATURE_IN_WIDTH 16
`endif
module buffer_reader #(
   parameter int DATA_WIDTH = `FEATURE_IN_WIDTH,
   parameter int DEPTH      = 4,
   parameter int FRAME_LEN  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic [DATA_WIDTH-1:0]   buf_data,
   input  logic                    buf_valid,
   output logic                    buf_hold,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic [$clog2(DEPTH):0]  fifo_count
`ifdef BUFFER_READER_STALL_CNT_EN
   ,
   output logic [15:0]             stall_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int FW = FRAME_LEN > 1 ? $clog2(FRAME_LEN) : 1;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]   count_q, count_d;
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [FW-1:0] fidx_q, fidx_d;
   logic          full, empty, push, pop;
   always_comb begin
      full      = count_q == (AW+1)'(DEPTH);
      empty     = count_q == '0;
      buf_hold  = full;
      out_valid = ~empty;
      out_data  = empty ? '0 : mem_q[rptr_q];
      out_last  = ~empty & (fidx_q == FW'(FRAME_LEN-1));
      fifo_count = count_q;
      // flush discards whatever transfer coincides with it
      push      = buf_valid & ~full & ~flush;
      pop       = out_valid & out_ready & ~flush;
      count_d   = flush ? '0 : count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      wptr_d    = flush ? '0 : push ? wptr_q + AW'(1) : wptr_q;
      rptr_d    = flush ? '0 : pop ? rptr_q + AW'(1) : rptr_q;
      fidx_d    = flush ? '0 : pop ? (fidx_q == FW'(FRAME_LEN-1) ? '0 : fidx_q + FW'(1)) : fidx_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         fidx_q  <= '0;
      end else begin
         count_q <= count_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         fidx_q  <= fidx_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= buf_data;
   end
`ifdef BUFFER_READER_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;
   always_comb begin
      stall_d   = flush ? '0 : (buf_valid & full & ~&stall_q) ? stall_q + 16'd1 : stall_q;
      stall_cnt = stall_q;
   end
   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end
`endif
endmodule

// File: tb/tb_buffer_reader.sv
// tb_buffer_reader: directed and randomized checks of buffer_reader against a queue-based reference model.
module tb_buffer_reader;
   localparam int DW = 16, DEPTH = 4, FL = 16;
   localparam int CW = $clog2(DEPTH) + 1;
   logic          clk = 1'b0;
   logic          rst, flush, buf_valid, out_ready;
   logic [DW-1:0] buf_data;
   logic          buf_hold, out_valid, out_last;
   logic [DW-1:0] out_data;
   logic [CW-1:0] fifo_count;
`ifdef BUFFER_READER_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif
   int            n_vec = 0, n_err = 0;
   logic [DW-1:0] q[$];
   int            fidx = 0, stall_m = 0, lasts;

   buffer_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst(rst), .flush(flush), .buf_data(buf_data), .buf_valid(buf_valid),
      .buf_hold(buf_hold), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .fifo_count(fifo_count)
`ifdef BUFFER_READER_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // check outputs against the model, then advance the model across one rising edge
   task automatic cycle();
      bit push, pop;
      int stall_nxt;
      chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("out_data", {16'd0, out_data}, q.size() != 0 ? {16'd0, q[0]} : 32'd0);
      chk("out_last", {31'd0, out_last}, {31'd0, q.size() != 0 && fidx == FL-1});
      chk("buf_hold", {31'd0, buf_hold}, {31'd0, q.size() == DEPTH});
      chk("fifo_count", {29'd0, fifo_count}, q.size());
`ifdef BUFFER_READER_STALL_CNT_EN
      chk("stall_cnt", {16'd0, stall_cnt}, stall_m);
`endif
      push = buf_valid && q.size() < DEPTH;
      pop = q.size() != 0 && out_ready;
      stall_nxt = (buf_valid && q.size() == DEPTH && stall_m < 65535) ? stall_m + 1 : stall_m;
      @(posedge clk);
      if (rst || flush) begin
         q.delete();
         fidx = 0;
         stall_m = 0;
      end else begin
         if (pop) begin
            void'(q.pop_front());
            fidx = (fidx + 1) % FL;
         end
         if (push) q.push_back(buf_data);
         stall_m = stall_nxt;
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; buf_valid = 1'b0; out_ready = 1'b0; buf_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      cycle();
      // stream 1..5 at full rate
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         buf_valid = 1'b1; buf_data = DW'(i);
         cycle();
         chk("stream_count_le1", {31'd0, fifo_count <= 1}, 32'd1);
      end
      buf_valid = 1'b0;
      cycle();
      // back-pressure: fill, hold 0xA5, then release
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         buf_valid = 1'b1; buf_data = DW'(16'hA0 + i);
         cycle();
      end
      buf_data = 16'hA5;
      repeat (3) cycle();
      chk("bp_hold", {31'd0, buf_hold}, 32'd1);
      out_ready = 1'b1;
      cycle();
      chk("bp_a5_after_pop", {29'd0, fifo_count}, 32'd3);
      cycle();
      chk("bp_a5_taken", {29'd0, fifo_count}, 32'd3);
      buf_valid = 1'b0;
      repeat (5) cycle();
      // frame marker over 32 words, aligned by a flush
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      lasts = 0;
      for (int i = 0; i < 33; i++) begin
         buf_valid = i < 32; buf_data = DW'(16'h100 + i);
         if (out_last) begin
            lasts++;
            chk("frame_last_word", {16'd0, out_data}, lasts == 1 ? 32'h10F : 32'h11F);
         end
         cycle();
      end
      chk("frame_last_total", lasts, 32'd2);
      buf_valid = 1'b1; buf_data = 16'h0BB;
      cycle();
      buf_valid = 1'b0;
      chk("frame_wrap_first", {31'd0, out_last}, 32'd0);
      cycle();
      // flush with count=3 alongside a push and a pop
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         buf_valid = 1'b1; buf_data = DW'(16'h300 + i);
         cycle();
      end
      chk("flush_pre_count", {29'd0, fifo_count}, 32'd3);
      flush = 1'b1; out_ready = 1'b1; buf_data = 16'h3FF;
      cycle();
      flush = 1'b0; buf_valid = 1'b0; out_ready = 1'b0;
      chk("flush_count", {29'd0, fifo_count}, 32'd0);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      cycle();
      buf_valid = 1'b1; buf_data = 16'h0077;
      cycle();
      buf_valid = 1'b0;
      chk("flush_next_word", {16'd0, out_data}, 32'h77);
      cycle();
`ifdef BUFFER_READER_STALL_CNT_EN
      flush = 1'b1;
      cycle();
      flush = 1'b0; out_ready = 1'b0; buf_valid = 1'b1;
      for (int i = 0; i < 4 + 7; i++) begin
         buf_data = DW'($urandom);
         cycle();
      end
      chk("stall_seven", {16'd0, stall_cnt}, 32'd7);
      buf_valid = 1'b0; flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("stall_flushed", {16'd0, stall_cnt}, 32'd0);
      cycle();
`endif
      // randomized traffic with occasional flush
      for (int i = 0; i < 400; i++) begin
         buf_valid = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         flush = $urandom_range(0, 39) == 0;
         buf_data = DW'($urandom);
         cycle();
      end
      flush = 1'b0; buf_valid = 1'b0; out_ready = 1'b1;
      repeat (DEPTH + 1) cycle();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
